// File: rtl/sysid_check_pkg.sv
`default_nettype none
// ============================================================================
// sysid_check_pkg : shared state encoding, fail codes and sysid word addresses
// Revision: 1.0
// ============================================================================
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_CHECK  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ID      = 2'd1;
  localparam logic [1:0] FAIL_TS      = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sysid_read_port.sv
`default_nettype none
// ============================================================================
// sysid_read_port : Avalon-MM read strobe/address hold, accept detect, latency
//                   counter and capture strobe for the sysid boot checker.
// Revision: 1.0
// ============================================================================
module sysid_read_port
  import sysid_check_pkg::*;
#(
  parameter int READ_LATENCY = 0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        addr_i,
  input  logic        chain_i,
  input  logic        abort_i,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  output logic        read_o,
  output logic        address_o,
  output logic        accept_o,
  output logic        capture_o,
  output logic [31:0] data_o
);

  logic read_q, read_d;
  logic addr_q, addr_d;
  logic w_accept;

  assign w_accept  = read_q & ~waitrequest_i;
  assign accept_o  = w_accept;
  assign read_o    = read_q;
  assign address_o = addr_q;
  assign data_o    = readdata_i;

  // A chained accept keeps read high and moves straight to the timestamp word.
  always_comb begin
    read_d = read_q;
    addr_d = addr_q;
    if (abort_i) begin
      read_d = 1'b0;
    end else if (read_q) begin
      if (w_accept) begin
        read_d = chain_i;
        addr_d = chain_i ? ADDR_TS : addr_q;
      end
    end else if (req_i) begin
      read_d = 1'b1;
      addr_d = addr_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      read_q <= 1'b0;
      addr_q <= ADDR_ID;
    end else begin
      read_q <= read_d;
      addr_q <= addr_d;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_lat_zero
      assign capture_o = w_accept;
    end else begin : g_lat_count
      logic [1:0] cnt_q;
      logic       pend_q;

      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          cnt_q  <= 2'd0;
          pend_q <= 1'b0;
        end else if (abort_i) begin
          pend_q <= 1'b0;
        end else if (w_accept) begin
          cnt_q  <= 2'(READ_LATENCY - 1);
          pend_q <= 1'b1;
        end else if (pend_q) begin
          if (cnt_q == 2'd0) begin
            pend_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
      end

      assign capture_o = pend_q && (cnt_q == 2'd0);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// sysid_boot_checker : reads the sysid ID and timestamp words, compares them to
//                      build-time values, retries and reports pass/fail.
// Optional waitrequest watchdog: define SYSID_CHECK_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1327911752,
  parameter int          READ_LATENCY       = 0,
  parameter int          MAX_RETRIES        = 3,
  parameter int          TIMEOUT_CYCLES     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  fail_code,
  output logic [3:0]  retry_count
);

  import sysid_check_pkg::*;

  generate
    if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
      $error("sysid_boot_checker: READ_LATENCY must be 0..3");
    end
    if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
      $error("sysid_boot_checker: MAX_RETRIES must be 0..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("sysid_boot_checker: TIMEOUT_CYCLES must be 1..65535");
    end
  endgenerate

  state_t      state_q;
  logic        busy_q, done_q, pass_q;
  logic [1:0]  fail_q;
  logic [3:0]  retry_q;
  logic [31:0] id_q, ts_q;

  logic        w_req, w_addr, w_chain;
  logic        w_accept, w_capture, w_timeout;
  logic        w_id_ok, w_ts_ok;
  logic [31:0] w_data;

  assign w_req   = (state_q == ST_REQ_ID) || (state_q == ST_REQ_TS);
  assign w_addr  = (state_q == ST_REQ_TS) ? ADDR_TS : ADDR_ID;
  assign w_chain = (state_q == ST_REQ_ID) && (READ_LATENCY == 0);
  assign w_id_ok = (id_q == EXPECTED_ID);
  assign w_ts_ok = (ts_q == EXPECTED_TIMESTAMP);

  sysid_read_port #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_port (
    .clock_i      (clock),
    .reset_i      (reset),
    .req_i        (w_req),
    .addr_i       (w_addr),
    .chain_i      (w_chain),
    .abort_i      (w_timeout),
    .waitrequest_i(waitrequest),
    .readdata_i   (readdata),
    .read_o       (read),
    .address_o    (address),
    .accept_o     (w_accept),
    .capture_o    (w_capture),
    .data_o       (w_data)
  );

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic [15:0] wd_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q <= 16'd0;
    end else if (read && waitrequest) begin
      wd_q <= wd_q + 16'd1;
    end else begin
      wd_q <= 16'd0;
    end
  end

  // Fires on the stalled cycle that completes TIMEOUT_CYCLES in a row.
  assign w_timeout = read && waitrequest && (wd_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= FAIL_NONE;
      retry_q <= 4'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
    end else if (w_timeout) begin
      state_q <= ST_FINISH;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
      pass_q  <= 1'b0;
      fail_q  <= FAIL_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            state_q <= ST_REQ_ID;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= FAIL_NONE;
            retry_q <= 4'd0;
          end
        end
        ST_REQ_ID: begin
          if (w_capture) begin
            id_q    <= w_data;
            state_q <= ST_REQ_TS;
          end else if (w_accept) begin
            state_q <= ST_LAT_ID;
          end
        end
        ST_LAT_ID: begin
          if (w_capture) begin
            id_q    <= w_data;
            state_q <= ST_REQ_TS;
          end
        end
        ST_REQ_TS: begin
          if (w_capture) begin
            ts_q    <= w_data;
            state_q <= ST_CHECK;
          end else if (w_accept) begin
            state_q <= ST_LAT_TS;
          end
        end
        ST_LAT_TS: begin
          if (w_capture) begin
            ts_q    <= w_data;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_id_ok && w_ts_ok) begin
            state_q <= ST_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
            fail_q  <= FAIL_NONE;
          end else begin
            fail_q <= w_id_ok ? FAIL_TS : FAIL_ID;
            if (retry_q < 4'(MAX_RETRIES)) begin
              retry_q <= retry_q + 4'd1;
              state_q <= ST_REQ_ID;
            end else begin
              state_q <= ST_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_q;
  assign retry_count = retry_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
`default_nettype wire

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master placed directly upstream of the system ID slave. It drives the slave's 1-bit address and consumes its 32-bit readdata.
- On start, it reads the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values.
- It retries on mismatch and reports pass/fail to the boot sequencer and host status register.
- Purpose: gates software boot until the hardware image is confirmed to match the compiled software.

Parameters:
- EXPECTED_ID, 32'd0, required value at address 0.
- EXPECTED_TIMESTAMP, 32'd1327911752, required value at address 1.
- READ_LATENCY, 0, cycles from read accept to valid readdata; legal range 0..3. Value 0 means readdata is sampled in the accept cycle.
- MAX_RETRIES, 3, extra full passes allowed after a mismatch; legal range 0..15.
- TIMEOUT_CYCLES, 1024, waitrequest watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a check.
- address  out  1  Avalon address to the sysid slave.
- read  out  1  Avalon read strobe.
- waitrequest  in  1  slave stall; tie to 0 for the sysid slave.
- readdata  in  32  slave read data.
- busy  out  1  high while a check is in progress.
- done  out  1  sticky completion flag.
- pass  out  1  valid while done=1; 1 means both words matched.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.
- fail_code  out  2  0 = none, 1 = ID mismatch, 2 = timestamp mismatch, 3 = timeout.
- retry_count  out  4  number of retries consumed.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-high, on port `reset`.
- Reset values:
  - address, read, busy, done, pass all 0.
  - id_value and ts_value 0.
  - fail_code 0, retry_count 0.
  - FSM in IDLE.
- Reset mid-operation: read drops asynchronously; no partial result is retained.
- FSM states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, CHECK, FINISH.
- IDLE:
  - start=1 → REQ_ID.
  - busy=1, done=0, pass=0, fail_code=0 and retry_count=0, all on the next edge.
- REQ_ID:
  - Drives read=1, address=0; both are held stable while waitrequest=1.
  - Accept means the edge on which read=1 and waitrequest=0.
  - READ_LATENCY=0: readdata is captured into id_value at the accept edge → REQ_TS.
  - READ_LATENCY>0: go to LAT_ID with read=0.
- LAT_ID:
  - A down-counter loaded with READ_LATENCY-1 at accept.
  - readdata is captured when the counter reaches 0 → REQ_TS.
- REQ_TS / LAT_TS: identical to REQ_ID / LAT_ID, with address=1 and capture into ts_value → CHECK.
- Back-to-back reads: no idle cycle is required between the two reads; at latency 0, REQ_TS follows REQ_ID directly.
- CHECK (one cycle):
  - Both words match → FINISH with pass=1, fail_code=0.
  - Otherwise fail_code is 1 if the ID mismatched (ID takes priority over timestamp), else 2.
  - On mismatch with retry_count<MAX_RETRIES: retry_count increments → REQ_ID.
  - On mismatch with retries exhausted → FINISH with pass=0.
- FINISH:
  - busy=0, done=1; pass, fail_code and the captured values are held.
  - start → behaves as from IDLE (clears flags, restarts).
- start while busy=1 is ignored.
- Minimum check latency (no waitrequest, READ_LATENCY=0): done rises 4 edges after the start edge.
- The comparison is exact 32-bit equality.
- retry_count saturates at MAX_RETRIES.

Optional Feature:
- Macro: SYSID_CHECK_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts consecutive cycles with read=1 and waitrequest=1, clearing on accept.
  - Reaching TIMEOUT_CYCLES → FINISH with pass=0, fail_code=3, read dropped on the same edge.
  - A timeout is not retried.
- Undefined:
  - No counter is instantiated.
  - The master waits on waitrequest indefinitely; fail_code never equals 3.

Decomposition:
- Package sysid_check_pkg:
  - FSM state enum.
  - fail_code localparams FAIL_NONE, FAIL_ID, FAIL_TS, FAIL_TIMEOUT.
  - Address constants ADDR_ID=0, ADDR_TS=1.
- One sub-module, sysid_read_port. It owns the read/address hold, accept detection, the latency counter and the capture strobe.
- The top-level module holds the FSM, comparators, retry logic and watchdog.

Test Plan:
- Happy path: readdata=0 at address 0, 1327911752 at address 1; latency 0, no stalls; start pulse → done=1 and pass=1 exactly 4 edges later, id_value=0, ts_value=1327911752, retry_count=0.
- Timestamp mismatch every pass: slave returns 1327911751 at address 1, MAX_RETRIES=3 → 4 full read pairs, then done=1, pass=0, fail_code=2, retry_count=3.
- Transient ID error: first ID read returns 32'hDEAD_BEEF, later reads correct → pass=1, retry_count=1, fail_code=0.
- Stalls and latency: waitrequest high for 5 cycles on each read, READ_LATENCY=2 → address and read held stable through the stall, data captured exactly 2 cycles after accept, pass=1.
- Timeout: with SYSID_CHECK_TIMEOUT_EN defined and TIMEOUT_CYCLES=20, waitrequest stuck at 1 → after 20 stalled cycles, read=0, done=1, fail_code=3. Without the macro defined, busy stays 1.
- Reset and start abuse:
  - Assert reset during LAT_TS → read and all flags 0 immediately; a later start gives a clean pass.
  - A second start while busy → ignored, exactly 2 reads issued.
